// File: rtl/display_msg_sel_pkg.sv
`default_nettype none
// ============================================================================
// display_msg_sel_pkg : display modes, baud codes and FSM state encodings
// Rev 1.0
// ============================================================================
package display_msg_sel_pkg;

    localparam logic BAUDRATE_MODE = 1'b0;
    localparam logic DATA_MODE     = 1'b1;

    localparam logic [1:0] BAUD_9600    = 2'd0;
    localparam logic [1:0] BAUD_57600   = 2'd1;
    localparam logic [1:0] BAUD_115200  = 2'd2;
    localparam logic [1:0] BAUD_INVALID = 2'd3;

    localparam logic SRC_TX = 1'b0;
    localparam logic SRC_RX = 1'b1;

    typedef enum logic [1:0] {
        SHOW_BAUD = 2'd0,
        BAUD_HOLD = 2'd1,
        SHOW_DATA = 2'd2
    } state_t;

    function automatic logic [7:0] baud_msg(input logic [1:0] sel);
        return {6'b0, sel};
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_msg_sel_hold_timer.sv
`default_nettype none
// ============================================================================
// hold_timer : saturating down-counter, load to HOLD_CYCLES-1, zero flag
// Rev 1.0
// ============================================================================
module hold_timer #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic tick_i,
    output logic zero_o
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(HOLD_CYCLES - 1);
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/display_msg_sel.sv
`default_nettype none
// ============================================================================
// display_msg_sel : chooses baud rate or last TX/RX byte for the digit display
// Rev 1.0
// ============================================================================
module display_msg_sel
    import display_msg_sel_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic       src_clk,
    input  logic       rst,
    input  logic [1:0] baud_sel,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       clr_ovr,
    output logic       mode,
    output logic [7:0] msg,
    output logic       data_src,
    output logic       overrun
);

    state_t     state_q;
    logic [1:0] baud_sel_q;
    logic       pend_v_q;
    logic [7:0] pend_data_q;
    logic       pend_src_q;
    logic       mode_q;
    logic [7:0] msg_q;
    logic       data_src_q;
    logic       overrun_q;
    logic       overrun_d;

    logic       baud_chg;
    logic       byte_ev;
    logic       byte_src;
    logic [7:0] byte_data;
    logic       hold_tick;
    logic       hold_zero;

    assign baud_chg  = (baud_sel != baud_sel_q);
    assign byte_ev   = tx_valid | rx_valid;
    assign byte_src  = rx_valid ? SRC_RX : SRC_TX;
    assign byte_data = rx_valid ? rx_data : tx_data;
    assign hold_tick = (state_q == BAUD_HOLD);

    // Loss sources: TX dropped in favour of RX, or a pending byte overwritten during hold.
    always_comb begin
        overrun_d = overrun_q;
        if ((tx_valid && rx_valid) || (hold_tick && pend_v_q && byte_ev)) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (src_clk),
        .rst   (rst),
        .load_i(baud_chg),
        .tick_i(hold_tick),
        .zero_o(hold_zero)
    );

    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            state_q     <= SHOW_BAUD;
            baud_sel_q  <= 2'b00;
            pend_v_q    <= 1'b0;
            pend_data_q <= 8'h00;
            pend_src_q  <= SRC_TX;
            mode_q      <= BAUDRATE_MODE;
            msg_q       <= 8'h00;
            data_src_q  <= SRC_TX;
            overrun_q   <= 1'b0;
        end else begin
            baud_sel_q <= baud_sel;
            overrun_q  <= overrun_d;
            case (state_q)
                SHOW_BAUD: begin
                    if (baud_chg) begin
                        state_q     <= BAUD_HOLD;
                        msg_q       <= baud_msg(baud_sel);
                        pend_v_q    <= byte_ev;
                        pend_data_q <= byte_data;
                        pend_src_q  <= byte_src;
                    end else if (byte_ev) begin
                        state_q    <= SHOW_DATA;
                        mode_q     <= DATA_MODE;
                        msg_q      <= byte_data;
                        data_src_q <= byte_src;
                    end
                end
                BAUD_HOLD: begin
                    if (baud_chg) begin
                        msg_q <= baud_msg(baud_sel);
                        if (byte_ev) begin
                            pend_v_q    <= 1'b1;
                            pend_data_q <= byte_data;
                            pend_src_q  <= byte_src;
                        end
                    end else if (hold_zero) begin
                        // A byte arriving on the expiry cycle is newer than the pending one.
                        pend_v_q <= 1'b0;
                        if (byte_ev) begin
                            state_q    <= SHOW_DATA;
                            mode_q     <= DATA_MODE;
                            msg_q      <= byte_data;
                            data_src_q <= byte_src;
                        end else if (pend_v_q) begin
                            state_q    <= SHOW_DATA;
                            mode_q     <= DATA_MODE;
                            msg_q      <= pend_data_q;
                            data_src_q <= pend_src_q;
                        end else begin
                            state_q <= SHOW_BAUD;
                            msg_q   <= baud_msg(baud_sel);
                        end
                    end else if (byte_ev) begin
                        pend_v_q    <= 1'b1;
                        pend_data_q <= byte_data;
                        pend_src_q  <= byte_src;
                    end
                end
                SHOW_DATA: begin
                    if (baud_chg) begin
                        state_q     <= BAUD_HOLD;
                        mode_q      <= BAUDRATE_MODE;
                        msg_q       <= baud_msg(baud_sel);
                        pend_v_q    <= byte_ev;
                        pend_data_q <= byte_data;
                        pend_src_q  <= byte_src;
                    end else if (byte_ev) begin
                        msg_q      <= byte_data;
                        data_src_q <= byte_src;
                    end
                end
                default: begin
                    state_q  <= SHOW_BAUD;
                    mode_q   <= BAUDRATE_MODE;
                    pend_v_q <= 1'b0;
                end
            endcase
        end
    end

    assign mode     = mode_q;
    assign msg      = msg_q;
    assign data_src = data_src_q;
    assign overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_display_msg_sel.sv
`default_nettype none
// ============================================================================
// tb_display_msg_sel : directed self-checking bench, HOLD_CYCLES = 8
// Rev 1.0
// ============================================================================
module tb_display_msg_sel;

    localparam int HOLD = 8;

    logic       clk;
    logic       rst;
    logic [1:0] baud_sel;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       clr_ovr;
    logic       mode;
    logic [7:0] msg;
    logic       data_src;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    display_msg_sel #(
        .HOLD_CYCLES(HOLD)
    ) dut (
        .src_clk (clk),
        .rst     (rst),
        .baud_sel(baud_sel),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .clr_ovr (clr_ovr),
        .mode    (mode),
        .msg     (msg),
        .data_src(data_src),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic tv, input logic [7:0] td, input logic rv, input logic [7:0] rd);
        tx_valid = tv; tx_data = td; rx_valid = rv; rx_data = rd;
        step(1);
        tx_valid = 1'b0; rx_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; baud_sel = 2'd2; clr_ovr = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00; rx_valid = 1'b0; rx_data = 8'h00;
        #2 rst = 1'b1;
        #2;
        chk("rst_mode", {7'b0, mode}, 8'h00);
        chk("rst_msg", msg, 8'h00);
        chk("rst_src", {7'b0, data_src}, 8'h00);
        chk("rst_ovr", {7'b0, overrun}, 8'h00);
        step(2);
        rst = 1'b0;

        // Nonzero baud_sel after release enters hold for 8 cycles
        step(1);
        chk("hold_entry_mode", {7'b0, mode}, 8'h00);
        chk("hold_entry_msg", msg, 8'h02);
        step(HOLD);

        // Back in SHOW_BAUD: RX byte displayed on the next edge
        send(1'b0, 8'h00, 1'b1, 8'h41);
        chk("rx41_mode", {7'b0, mode}, 8'h01);
        chk("rx41_msg", msg, 8'h41);
        chk("rx41_src", {7'b0, data_src}, 8'h01);

        // Hold with two TX bytes: newest pending wins, overrun set
        baud_sel = 2'd0;
        step(1);
        chk("f1_mode", {7'b0, mode}, 8'h00);
        chk("f1_msg", msg, 8'h00);
        send(1'b1, 8'h30, 1'b0, 8'h00);
        send(1'b1, 8'h31, 1'b0, 8'h00);
        chk("f3_msg", msg, 8'h00);
        chk("f3_mode", {7'b0, mode}, 8'h00);
        chk("f3_ovr", {7'b0, overrun}, 8'h01);
        step(5);
        chk("f8_mode", {7'b0, mode}, 8'h00);
        step(1);
        chk("f9_mode", {7'b0, mode}, 8'h01);
        chk("f9_msg", msg, 8'h31);
        chk("f9_src", {7'b0, data_src}, 8'h00);
        clr_ovr = 1'b1;
        step(1);
        clr_ovr = 1'b0;
        chk("clr1_ovr", {7'b0, overrun}, 8'h00);

        // Simultaneous TX/RX: RX wins, overrun set; set beats clear
        send(1'b1, 8'h55, 1'b1, 8'h66);
        chk("both_msg", msg, 8'h66);
        chk("both_src", {7'b0, data_src}, 8'h01);
        chk("both_ovr", {7'b0, overrun}, 8'h01);
        clr_ovr = 1'b1;
        send(1'b1, 8'h10, 1'b1, 8'h20);
        chk("setclr_ovr", {7'b0, overrun}, 8'h01);
        chk("setclr_msg", msg, 8'h20);
        step(1);
        clr_ovr = 1'b0;
        chk("clr2_ovr", {7'b0, overrun}, 8'h00);

        // Baud change from SHOW_DATA, second change at hold cycle 5 restarts hold
        baud_sel = 2'd1;
        step(1);
        chk("h1_mode", {7'b0, mode}, 8'h00);
        chk("h1_msg", msg, 8'h01);
        step(3);
        baud_sel = 2'd2;
        step(1);
        chk("h5_msg", msg, 8'h02);
        send(1'b0, 8'h00, 1'b1, 8'h77);
        chk("h6_msg", msg, 8'h02);
        step(6);
        chk("h12_mode", {7'b0, mode}, 8'h00);
        step(1);
        chk("h13_mode", {7'b0, mode}, 8'h01);
        chk("h13_msg", msg, 8'h77);
        chk("h13_src", {7'b0, data_src}, 8'h01);
        chk("h13_ovr", {7'b0, overrun}, 8'h00);

        // Invalid baud forwarded; reset mid-hold discards pending byte
        baud_sel = 2'd3;
        step(1);
        chk("baud3_msg", msg, 8'h03);
        send(1'b1, 8'h99, 1'b0, 8'h00);
        step(2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_mode", {7'b0, mode}, 8'h00);
        chk("mid_rst_msg", msg, 8'h00);
        chk("mid_rst_src", {7'b0, data_src}, 8'h00);
        baud_sel = 2'd0;
        step(1);
        rst = 1'b0;
        step(HOLD + 2);
        chk("post_rst_mode", {7'b0, mode}, 8'h00);
        chk("post_rst_msg", msg, 8'h00);

        // Baud change and byte in same cycle: baud wins, byte shown after hold
        baud_sel = 2'd1;
        send(1'b1, 8'h12, 1'b0, 8'h00);
        chk("l1_mode", {7'b0, mode}, 8'h00);
        chk("l1_msg", msg, 8'h01);
        step(HOLD - 1);
        chk("l8_mode", {7'b0, mode}, 8'h00);
        step(1);
        chk("l9_mode", {7'b0, mode}, 8'h01);
        chk("l9_msg", msg, 8'h12);
        chk("l9_src", {7'b0, data_src}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_msg_sel.md
DISPLAY_MSG_SEL -- requirements
Module: display_msg_sel

Interface
REQ-001 Parameter HOLD_CYCLES, default 50_000_000: number of src_clk cycles the baud rate stays on display after a baud_sel change (1 s at 50 MHz).
REQ-002 src_clk  input  1  single clock; all logic is rising-edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 baud_sel  input  2  current baud selection: 0=9600, 1=57600, 2=115200, 3=invalid.
REQ-005 tx_valid  input  1  one-cycle strobe: tx_data is being transmitted.
REQ-006 tx_data  input  8  transmitted byte.
REQ-007 rx_valid  input  1  one-cycle strobe: rx_data has been received.
REQ-008 rx_data  input  8  received byte.
REQ-009 clr_ovr  input  1  synchronous clear of overrun.
REQ-010 mode  output  1  display mode for the digit display stage (BAUDRATE_MODE / DATA_MODE).
REQ-011 msg  output  8  display payload: {6'b0, baud_sel} in baud mode, byte in data mode.
REQ-012 data_src  output  1  source of the byte on display: 0=TX, 1=RX.
REQ-013 overrun  output  1  sticky flag: a byte event was lost.

Function
REQ-014 All outputs SHALL be registered; an input event SHALL become visible on the outputs exactly 1 cycle after the edge that samples it.
REQ-015 A baud change SHALL be detected as baud_sel != baud_sel_q, where baud_sel_q is baud_sel registered every cycle.
REQ-016 FSM states: SHOW_BAUD, BAUD_HOLD, SHOW_DATA.
REQ-017 SHOW_BAUD: mode=BAUDRATE_MODE, msg={6'b0,baud_sel}; a byte event -> SHOW_DATA; a baud change -> BAUD_HOLD.
REQ-018 BAUD_HOLD: mode=BAUDRATE_MODE; hold counter loads HOLD_CYCLES-1 on entry and decrements each cycle.
REQ-019 BAUD_HOLD: a byte event SHALL be stored in a one-entry pending register (newest wins) and SHALL NOT change the display.
REQ-020 BAUD_HOLD: a further baud change SHALL reload the counter and update msg.
REQ-021 BAUD_HOLD at counter=0: pending valid -> SHOW_DATA showing the pending byte and source, pending cleared; otherwise -> SHOW_BAUD.
REQ-022 SHOW_DATA: mode=DATA_MODE, msg=last byte; each new byte event replaces msg and data_src; a baud change -> BAUD_HOLD with pending cleared.
REQ-023 Simultaneous tx_valid and rx_valid: RX SHALL win, the TX byte SHALL be dropped and overrun set.
REQ-024 A pending byte overwritten in BAUD_HOLD SHALL set overrun.
REQ-025 A baud change and a byte event in the same cycle: the baud change wins; the byte goes to pending.
REQ-026 overrun SHALL remain set until clr_ovr or rst; a set condition in the same cycle as clr_ovr SHALL leave overrun set.
REQ-027 baud_sel=3 SHALL be forwarded unchanged in msg; the display stage blanks it.
REQ-028 The hold counter SHALL be sized $clog2(HOLD_CYCLES) bits and SHALL NOT wrap below 0.

Reset
REQ-029 rst SHALL force: state=SHOW_BAUD, mode=BAUDRATE_MODE, msg=8'h00, data_src=0, overrun=0, pending empty, counter=0, baud_sel_q=2'b00.
REQ-030 A nonzero baud_sel after reset release SHALL register as a baud change and enter BAUD_HOLD.
REQ-031 rst asserted mid-hold or mid-data SHALL discard pending and the counter immediately.

Structure
REQ-032 BAUDRATE_MODE, DATA_MODE, the baud select codes and the state encodings SHALL live in the shared common include.
REQ-033 The hold timer SHALL be one sub-module, hold_timer (load, tick, zero flag).

Verification
REQ-034 Use HOLD_CYCLES=8: reset, baud_sel=2 -> cycle after release: BAUD_HOLD, msg=8'h02; 8 cycles later: SHOW_BAUD.
REQ-035 In SHOW_BAUD, rx_valid with rx_data=8'h41 -> next cycle mode=DATA_MODE, msg=8'h41, data_src=1.
REQ-036 In BAUD_HOLD, tx 8'h30 then tx 8'h31 -> display unchanged, overrun=1; at expiry msg=8'h31, data_src=0.
REQ-037 Same-cycle tx 8'h55 / rx 8'h66 in SHOW_DATA -> msg=8'h66, data_src=1, overrun=1; clr_ovr -> overrun=0.
REQ-038 In SHOW_DATA, baud_sel 0->1 -> next cycle mode=BAUDRATE_MODE, msg=8'h01; a second change at hold cycle 5 restarts the full 8-cycle hold.
REQ-039 rst pulse during BAUD_HOLD with a pending byte -> reset values immediately; the pending byte is never displayed.
